// File: rtl/sm_program_loader_pkg.sv
// Shared state encoding and constants for the boot-time program loader.
package sm_program_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE = 3'd0,
    LDR_LEN0 = 3'd1,
    LDR_LEN1 = 3'd2,
    LDR_DATA = 3'd3,
    LDR_CHK  = 3'd4,
    LDR_RUN  = 3'd5,
    LDR_ERR  = 3'd6
  } ldr_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // States in which the inter-byte idle timer is armed.
  function automatic logic is_loading(input ldr_state_t s);
    return (s == LDR_LEN0) || (s == LDR_LEN1) || (s == LDR_DATA) || (s == LDR_CHK);
  endfunction

endpackage

// File: rtl/sm_timeout_counter.sv
// Idle-cycle counter: expired is raised while enabled once TIMEOUT-1 cycles
// have passed without a clear.
module sm_timeout_counter #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || clear) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/sm_program_loader.sv
// Boot loader: assembles UART bytes into little-endian words, writes instruction
// memory, and holds the CPU in reset until a checksum-valid image has landed.
module sm_program_loader
  import sm_program_loader_pkg::*;
#(
  parameter int         ADDR_W  = 6,
  parameter int         TIMEOUT = 1000000,
  parameter logic [7:0] SYNC    = SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxValid,
  input  logic [7:0]        rxData,
  output logic              imWe,
  output logic [ADDR_W-1:0] imWAddr,
  output logic [31:0]       imWData,
  output logic              cpuRst_n,
  output logic              loadBusy,
  output logic              loadDone,
  output logic              loadErr
);

  localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

  ldr_state_t        state_q, state_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic              we_d, cpu_rst_n_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [31:0]       wdata_d;
  logic [15:0]       len_full;
  logic              expired, go_err;

  assign len_full = {rxData, len_lo_q};

  sm_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (is_loading(state_q)),
    .clear  (rxValid),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    word_d      = word_q;
    last_d      = last_q;
    len_lo_d    = len_lo_q;
    we_d        = 1'b0;
    waddr_d     = imWAddr;
    wdata_d     = imWData;
    cpu_rst_n_d = cpuRst_n;
    busy_d      = loadBusy;
    done_d      = loadDone;
    err_d       = loadErr;
    go_err      = 1'b0;

    case (state_q)
      LDR_IDLE, LDR_RUN: begin
        if (rxValid && (rxData == SYNC)) begin
          state_d     = LDR_LEN0;
          cpu_rst_n_d = 1'b0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          word_d      = '0;
          idx_d       = '0;
          chk_d       = '0;
        end
      end
      LDR_LEN0: begin
        if (rxValid) begin
          len_lo_d = rxData;
          state_d  = LDR_LEN1;
        end else if (expired) begin
          go_err = 1'b1;
        end
      end
      LDR_LEN1: begin
        if (rxValid) begin
          last_d = ADDR_W'(len_full - 16'd1);
          if ({1'b0, len_full} > CAPACITY) go_err = 1'b1;
          else if (len_full == 16'd0)      state_d = LDR_CHK;
          else                             state_d = LDR_DATA;
        end else if (expired) begin
          go_err = 1'b1;
        end
      end
      LDR_DATA: begin
        if (rxValid) begin
          chk_d = chk_q ^ rxData;
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: asm_d[7:0]   = rxData;
            2'd1: asm_d[15:8]  = rxData;
            2'd2: asm_d[23:16] = rxData;
            default: begin
              // Final byte goes straight to the write port; no need to park it.
              we_d    = 1'b1;
              waddr_d = word_q;
              wdata_d = {rxData, asm_q};
              word_d  = word_q + ADDR_W'(1);
              if (word_q == last_q) state_d = LDR_CHK;
            end
          endcase
        end else if (expired) begin
          go_err = 1'b1;
        end
      end
      LDR_CHK: begin
        if (rxValid) begin
          if (rxData == chk_q) begin
            state_d     = LDR_RUN;
            cpu_rst_n_d = 1'b1;
            done_d      = 1'b1;
            busy_d      = 1'b0;
          end else begin
            go_err = 1'b1;
          end
        end else if (expired) begin
          go_err = 1'b1;
        end
      end
      LDR_ERR: state_d = LDR_IDLE;
      default: state_d = LDR_IDLE;
    endcase

    if (go_err) begin
      state_d     = LDR_ERR;
      err_d       = 1'b1;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      cpu_rst_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LDR_IDLE;
      asm_q    <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      word_q   <= '0;
      last_q   <= '0;
      len_lo_q <= '0;
      imWe     <= 1'b0;
      imWAddr  <= '0;
      imWData  <= '0;
      cpuRst_n <= 1'b0;
      loadBusy <= 1'b0;
      loadDone <= 1'b0;
      loadErr  <= 1'b0;
    end else begin
      state_q  <= state_d;
      asm_q    <= asm_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      word_q   <= word_d;
      last_q   <= last_d;
      len_lo_q <= len_lo_d;
      imWe     <= we_d;
      imWAddr  <= waddr_d;
      imWData  <= wdata_d;
      cpuRst_n <= cpu_rst_n_d;
      loadBusy <= busy_d;
      loadDone <= done_d;
      loadErr  <= err_d;
    end
  end

endmodule

// File: tb/tb_sm_program_loader.sv
// Scoreboard bench for sm_program_loader: frames are modelled as word lists,
// expected memory writes are queued and a monitor checks each imWe pulse.
module tb_sm_program_loader;

  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rxValid = 1'b0;
  logic [7:0]        rxData = 8'h00;
  logic              imWe;
  logic [ADDR_W-1:0] imWAddr;
  logic [31:0]       imWData;
  logic              cpuRst_n, loadBusy, loadDone, loadErr;

  sm_program_loader #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .SYNC   (SYNC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rxValid (rxValid),
    .rxData  (rxData),
    .imWe    (imWe),
    .imWAddr (imWAddr),
    .imWData (imWData),
    .cpuRst_n(cpuRst_n),
    .loadBusy(loadBusy),
    .loadDone(loadDone),
    .loadErr (loadErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];
  logic [7:0]        tx_byte[$];
  int                tx_gap[$];
  logic [31:0]       words[$];
  bit                rand_gaps = 1'b0;
  bit                exp_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && imWe) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h with none expected", imWAddr, imWData);
      end else begin
        check("write_addr", 32'(imWAddr), 32'(exp_addr_q.pop_front()));
        check("write_data", imWData, exp_data_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1);
  end

  task automatic drive(input bit v, input logic [7:0] d);
    @(negedge clk);
    rxValid = v;
    rxData  = v ? d : 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  function automatic int pick_gap();
    if (!rand_gaps) return 0;
    if ($urandom_range(0, 9) < 7) return 0;
    return int'($urandom_range(1, TIMEOUT - 1));
  endfunction

  task automatic push_byte(input logic [7:0] b);
    tx_byte.push_back(b);
    tx_gap.push_back(pick_gap());
  endtask

  // Reference model: derives the byte stream, expected writes and outcome
  // from a word list. mode 0 good, 1 bad checksum, 2 header only, 3 truncated.
  task automatic build_frame(input int mode, input int len, input int nbytes);
    logic [7:0]  chk;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] len16;
    int          total;
    chk   = 8'h00;
    len16 = 16'(len);
    tx_byte.delete();
    tx_gap.delete();
    push_byte(SYNC);
    push_byte(len16[7:0]);
    push_byte(len16[15:8]);
    exp_ok = 1'b0;
    if (mode == 2) return;
    total = (mode == 3) ? nbytes : 4 * len;
    for (int i = 0; i < total; i++) begin
      w   = words[i / 4];
      b   = w[8 * (i % 4) +: 8];
      chk = chk ^ b;
      push_byte(b);
      if (i % 4 == 3) begin
        exp_addr_q.push_back(ADDR_W'(i / 4));
        exp_data_q.push_back(w);
      end
    end
    if (mode == 0) begin
      push_byte(chk);
      exp_ok = 1'b1;
    end else if (mode == 1) begin
      push_byte(chk ^ 8'($urandom_range(1, 255)));
    end
  endtask

  task automatic send_stream();
    for (int i = 0; i < tx_byte.size(); i++) begin
      idle(tx_gap[i]);
      drive(1'b1, tx_byte[i]);
    end
    drive(1'b0, 8'h00);
  endtask

  task automatic fill_words(input int len);
    logic [31:0] w;
    words.delete();
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w[8 * $urandom_range(0, 3) +: 8] = SYNC;
      words.push_back(w);
    end
  endtask

  task automatic check_status(input string tag, input bit ok);
    check({tag, "_done"}, 32'(loadDone), 32'(ok));
    check({tag, "_err"}, 32'(loadErr), 32'(!ok));
    check({tag, "_cpu"}, 32'(cpuRst_n), 32'(ok));
    check({tag, "_busy"}, 32'(loadBusy), 32'd0);
    check({tag, "_pending_writes"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    int mode, len, nbytes;

    // Reset values, then a long quiet period.
    idle(3);
    check("rst_we", 32'(imWe), 32'd0);
    check("rst_addr", 32'(imWAddr), 32'd0);
    check("rst_data", imWData, 32'd0);
    check("rst_cpu", 32'(cpuRst_n), 32'd0);
    check("rst_flags", {29'd0, loadBusy, loadDone, loadErr}, 32'd0);
    rst_n = 1'b1;
    idle(100);
    check("quiet_cpu", 32'(cpuRst_n), 32'd0);
    check("quiet_flags", {29'd0, loadBusy, loadDone, loadErr}, 32'd0);

    // Two-word reference image, CPU released the cycle after CHK.
    words = '{32'h00100513, 32'h00200593};
    build_frame(0, 2, 0);
    send_stream();
    check_status("ref_frame", 1'b1);

    // Corrupted checksum, then recovery with a good frame.
    build_frame(1, 2, 0);
    send_stream();
    check_status("bad_chk", 1'b0);
    build_frame(0, 2, 0);
    send_stream();
    check_status("recover", 1'b1);

    // LEN one beyond capacity: error the cycle after LEN_HI.
    build_frame(2, 65, 0);
    send_stream();
    check_status("oversize", 1'b0);

    // Timeout boundary: silence of TIMEOUT cycles errors, TIMEOUT-1 does not.
    drive(1'b1, SYNC); drive(1'b1, 8'h01); drive(1'b1, 8'h00); drive(1'b1, 8'h13);
    idle(TIMEOUT);
    check("to_edge_err", 32'(loadErr), 32'd0);
    check("to_edge_busy", 32'(loadBusy), 32'd1);
    drive(1'b0, 8'h00);
    check_status("timeout", 1'b0);
    exp_addr_q.push_back('0);
    exp_data_q.push_back(32'h00100513);
    drive(1'b1, SYNC); drive(1'b1, 8'h01); drive(1'b1, 8'h00); drive(1'b1, 8'h13);
    idle(TIMEOUT - 1);
    drive(1'b1, 8'h05); drive(1'b1, 8'h10); drive(1'b1, 8'h00);
    drive(1'b1, 8'h13 ^ 8'h05 ^ 8'h10 ^ 8'h00);
    drive(1'b0, 8'h00);
    check_status("late_byte", 1'b1);

    // Empty image, then a restart while running.
    drive(1'b1, SYNC); drive(1'b1, 8'h00); drive(1'b1, 8'h00); drive(1'b1, 8'h00);
    drive(1'b0, 8'h00);
    check_status("empty", 1'b1);
    drive(1'b1, SYNC);
    drive(1'b0, 8'h00);
    check("restart_cpu", 32'(cpuRst_n), 32'd0);
    check("restart_busy", 32'(loadBusy), 32'd1);
    check("restart_done", 32'(loadDone), 32'd0);
    idle(TIMEOUT + 2);
    check_status("restart_to", 1'b0);

    // Asynchronous reset in the middle of a load.
    drive(1'b1, SYNC); drive(1'b1, 8'h02); drive(1'b1, 8'h00);
    drive(1'b1, 8'h11); drive(1'b1, 8'h22); drive(1'b1, 8'h33);
    rxValid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("midrst_flags", {28'd0, cpuRst_n, loadBusy, loadDone, loadErr}, 32'd0);
    check("midrst_addr", 32'(imWAddr), 32'd0);
    idle(2);
    rst_n = 1'b1;

    // Full-capacity image with random pacing.
    rand_gaps = 1'b1;
    fill_words(64);
    build_frame(0, 64, 0);
    send_stream();
    idle(TIMEOUT + 2);
    check_status("full", 1'b1);

    // Randomized frames of every kind.
    for (int f = 0; f < 40; f++) begin
      mode = int'($urandom_range(0, 3));
      if (mode == 2) len = int'($urandom_range(65, 65535));
      else if ($urandom_range(0, 7) == 0) len = int'($urandom_range(9, 64));
      else len = int'($urandom_range(0, 8));
      nbytes = (mode == 3) ? int'($urandom_range(0, 4 * len)) : 0;
      if (mode != 2) fill_words(len);
      build_frame(mode, len, nbytes);
      send_stream();
      idle(TIMEOUT + 2);
      check_status("rand", exp_ok);
    end

    idle(4);
    check("final_pending", 32'(exp_addr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
